// File: rtl/mem_lsu_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// The LSU takes the slave modport; the core/memory environment takes master.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store initiator for a word-wide memory: little-endian lane extraction on
// loads, read-modify-write for byte/half stores, alignment and size checking.
module mem_lsu (
  input  logic       clk,
  input  logic       reset,
  mem_lsu_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bad_req;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic        [31:0] r;
    b  = word[{off, 3'b000} +: 8];
    h  = off[1] ? word[31:16] : word[15:0];
    sb = signed'(b);
    sh = signed'(h);
    case (size)
      2'b00:   r = uns ? {24'd0, b} : 32'(sb);
      2'b01:   r = uns ? {16'd0, h} : 32'(sh);
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wd,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) r[{off, 3'b000} +: 8] = wd[7:0];
    else               r[{off[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  assign bad_req = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata[15:0];
          if (bad_req) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = RESP;
          end else if (!bus.req_we) begin
            state_d = LOAD;
          end else if (bus.req_size == 2'b10) begin
            merge_d = bus.req_wdata;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      LOAD: begin
        rdata_d = load_extend(bus.mem_rd, size_q, addr_q[1:0], uns_q);
        err_d   = 1'b0;
        state_d = RESP;
      end
      READ: begin
        merge_d = merge_lane(bus.mem_rd, wdata_q, size_q, addr_q[1:0]);
        state_d = WRITE;
      end
      WRITE: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 16'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write enable is gated by reset so an aborted store never commits.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP) && !reset;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_we     = (state_q == WRITE) && !reset;
  assign bus.mem_a      = {addr_q[31:2], 2'b00};
  assign bus.mem_wd     = merge_q;
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator that sits between the core's memory stage and the word-wide data memory (combinational read, synchronous write on `we`). Accepts byte, halfword and word load/store requests over a valid/ready handshake. It performs little-endian lane extraction with sign or zero extension for loads. It turns sub-word stores into a read-modify-write sequence, since the memory only writes full 32-bit words.

## Interface
Parameters:
- none (address and data are fixed at 32 bits)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  core presents a request
- `req_ready`  out  1  LSU can accept a request this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `resp_valid`  out  1  one-cycle pulse: request complete
- `resp_rdata`  out  32  load result; 0 for stores and errors; held until next response
- `resp_err`  out  1  misaligned or illegal size; held until next response
- `mem_we`  out  1  memory write enable
- `mem_a`  out  32  memory address, always word-aligned ({addr[31:2],2'b00})
- `mem_wd`  out  32  memory write data
- `mem_rd`  in  32  memory read data, combinational from `mem_a`

## Operation
- FSM states: IDLE, LOAD, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch we, size, unsigned, addr and wdata.
  - Illegal size, half with addr[0]=1, or word with addr[1:0]≠0 → RESP with err=1. No memory write.
  - Load → LOAD. Word store → WRITE, with merge register = wdata. Byte/half store → READ.
- LOAD: capture `mem_rd`. Select lane: byte = addr[1:0]*8, half = addr[1]*16. Extend per `unsigned` into `resp_rdata`. → RESP.
- READ: merge register = `mem_rd` with the addressed byte or half replaced by wdata[7:0] or wdata[15:0]. All other bytes are unchanged. → WRITE.
- WRITE: `mem_we` = 1, `mem_wd` = merge register. → RESP.
- RESP: `resp_valid` = 1, `resp_err` updated. `resp_rdata` is updated to 0 for stores and errors. → IDLE.
- `req_ready` = 0 in every state except IDLE. Requests offered in other states are ignored and not latched.
- `mem_wd` always equals the merge register. `mem_a` always derives from the latched address. Both are undefined to the memory unless `mem_we`=1.
- Little-endian: byte lane 0 = bits [7:0].

## Timing
- Reset values: state IDLE; `req_ready`=1 (combinational from IDLE); `resp_valid`=0; `resp_rdata`=0; `resp_err`=0; `mem_we`=0; latched address=0, so `mem_a`=0; merge register=0, so `mem_wd`=0.
- Request accepted at edge T (IDLE, `req_valid`=1). `resp_valid` is high during:
  - load: cycle T+2
  - word store: T+2, with the write committing at the edge ending T+1
  - byte/half store: T+3, with the read in T+1 and the write committing at the edge ending T+2
  - error: T+1
- Back-to-back operation: the next request can be accepted in the cycle after RESP. Minimum initiation interval is 3 cycles for loads and word stores, 4 for sub-word stores, 2 for errors.
- `mem_we` = (state==WRITE) && !reset. Reset asserted during WRITE must not commit the write.
- Reset in any state: the next state is IDLE. No `resp_valid` is issued for the aborted request.
- A load's `mem_rd` is sampled in the same cycle `mem_a` is driven; no extra wait state.

## Test plan
- Memory word at 0x10 = 0x8899AABB. Byte load, signed, addr 0x11 → `resp_valid` at T+2, `resp_rdata`=0xFFFFFFAA. The same load unsigned → 0x000000AA.
- Memory word at 0x10 = 0x8899AABB. Signed half load at 0x12 → 0xFFFF8899. Word load at 0x10 → 0x8899AABB.
- Memory word at 0x20 = 0x11223344. Byte store 0x5A at 0x23 → one `mem_we` pulse at T+2 with `mem_a`=0x20, `mem_wd`=0x5A223344. `resp_valid` at T+3. A subsequent word load returns 0x5A223344.
- Word store 0xDEADBEEF at 0x24 → `mem_we` in T+1 only. A half store 0xCAFE at 0x26 then yields 0xCAFEBEEF.
- Half load at 0x01, word store at 0x06, and size 11 → each gives `resp_err`=1 at T+1, `resp_rdata`=0, and no `mem_we`.
- Byte store with `reset` asserted in the WRITE cycle → memory is unchanged, no `resp_valid`, and `req_ready`=1 the next cycle. `req_valid` held high during a busy LSU → only one request is latched.
